// File: rtl/cpu_pkg.sv
// Shared CPU definitions: command word geometry, opcode constants and the
// state encoding of the command-memory loader.
package cpu_pkg;

    // Command word and command memory geometry
    localparam int CMD_SIZE      = 19;
    localparam int CMD_MEM_SIZE  = 32;
    localparam int CMD_ADDR_SIZE = $clog2(CMD_MEM_SIZE);

    // Byte stream framing
    localparam int BYTE_SIZE     = 8;
    localparam int BYTES_PER_CMD = 3;

    // Bits of a command carried by the first (most significant) byte
    localparam int CMD_HI_BITS   = CMD_SIZE - 2 * BYTE_SIZE;

    // Word counter must hold the value CMD_MEM_SIZE itself, hence one extra bit
    localparam int WORD_CNT_SIZE = CMD_ADDR_SIZE + 1;

    // Largest legal frame header, expressed at byte width
    localparam logic [BYTE_SIZE-1:0] MAX_WORDS = BYTE_SIZE'(CMD_MEM_SIZE);

    // CPU opcode constants
    typedef enum logic [3:0] {
        OP_NOP = 4'd0,
        OP_ADD = 4'd1,
        OP_SUB = 4'd2,
        OP_AND = 4'd3,
        OP_OR  = 4'd4,
        OP_XOR = 4'd5,
        OP_SHL = 4'd6,
        OP_SHR = 4'd7,
        OP_LDI = 4'd8,
        OP_LD  = 4'd9,
        OP_ST  = 4'd10,
        OP_BEQ = 4'd11,
        OP_BNE = 4'd12,
        OP_JMP = 4'd13
    } opcode_e;

    // Loader state encoding
    typedef enum logic [2:0] {
        LD_IDLE  = 3'd0,
        LD_DATA  = 3'd1,
        LD_CHECK = 3'd2,
        LD_DONE  = 3'd3,
        LD_ERROR = 3'd4
    } loader_state_e;

    // A frame header is usable when it names between 1 and CMD_MEM_SIZE words
    function automatic logic header_ok(input logic [BYTE_SIZE-1:0] n);
        return (n != '0) && (n <= MAX_WORDS);
    endfunction

    // The leading byte of each word may only use its low CMD_HI_BITS bits
    function automatic logic pad_ok(input logic [BYTE_SIZE-1:0] b);
        return (b[BYTE_SIZE-1:CMD_HI_BITS] == '0);
    endfunction

endpackage

// File: rtl/cmd_word_assembler.sv
// Collects three MSB-first bytes into one command word. The word is presented
// combinationally alongside word_valid_o on the cycle its last byte is
// accepted, so the loader can register it straight onto the memory port.
module cmd_word_assembler
    import cpu_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear_i,
    input  logic                 accept_i,
    input  logic [BYTE_SIZE-1:0] data_i,
    output logic                 pad_err_o,
    output logic                 word_valid_o,
    output logic [CMD_SIZE-1:0]  word_o
);

    logic [1:0]             idx_q;
    logic [CMD_HI_BITS-1:0] hi_q;
    logic [BYTE_SIZE-1:0]   mid_q;

    // A leading byte with non-zero padding is flagged as it is accepted
    assign pad_err_o    = accept_i && (idx_q == 2'd0) && !pad_ok(data_i);
    assign word_valid_o = accept_i && (idx_q == 2'd2);
    assign word_o       = {hi_q, mid_q, data_i};

    // Byte index and partial word storage; clear_i abandons any partial word
    always_ff @(posedge clk) begin
        if (!reset || clear_i) begin
            idx_q <= 2'd0;
            hi_q  <= '0;
            mid_q <= '0;
        end else if (accept_i) begin
            if (idx_q == 2'd0) begin
                hi_q  <= data_i[CMD_HI_BITS-1:0];
                idx_q <= 2'd1;
            end else if (idx_q == 2'd1) begin
                mid_q <= data_i;
                idx_q <= 2'd2;
            end else begin
                idx_q <= 2'd0;
            end
        end
    end

endmodule

// File: rtl/cmd_loader.sv
// Loads a framed byte stream into CPU command memory and keeps the CPU in
// reset until a complete frame with a good checksum has been written.
module cmd_loader
    import cpu_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic [BYTE_SIZE-1:0]     in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     start,
    output logic                     wr_en,
    output logic [CMD_ADDR_SIZE-1:0] wr_addr,
    output logic [CMD_SIZE-1:0]      wr_data,
    output logic                     cpu_hold,
    output logic                     done,
    output logic                     err
);

    loader_state_e            state_q;
    logic                     in_ready_q;
    logic                     wr_en_q;
    logic [CMD_ADDR_SIZE-1:0] wr_addr_q;
    logic [CMD_SIZE-1:0]      wr_data_q;
    logic                     cpu_hold_q;
    logic                     done_q;
    logic                     err_q;
    logic [WORD_CNT_SIZE-1:0] n_q;
    logic [WORD_CNT_SIZE-1:0] cnt_q;
    logic [WORD_CNT_SIZE-1:0] cnt_plus1;
    logic [BYTE_SIZE-1:0]     csum_q;

    logic                     byte_accept;
    logic                     data_accept;
    logic                     restart;
    logic                     pad_err;
    logic                     word_valid;
    logic [CMD_SIZE-1:0]      word;

    // in_ready is registered, so a transfer never depends combinationally on outputs
    assign byte_accept = in_valid && in_ready_q;
    assign data_accept = byte_accept && (state_q == LD_DATA);
    assign restart     = start && ((state_q == LD_DONE) || (state_q == LD_ERROR));
    assign cnt_plus1   = cnt_q + WORD_CNT_SIZE'(1);

    cmd_word_assembler u_assembler (
        .clk          (clk),
        .reset        (reset),
        .clear_i      (restart),
        .accept_i     (data_accept),
        .data_i       (in_data),
        .pad_err_o    (pad_err),
        .word_valid_o (word_valid),
        .word_o       (word)
    );

    // Frame sequencing, word counting, checksum and all registered outputs
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= LD_IDLE;
            in_ready_q <= 1'b1;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            cpu_hold_q <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            n_q        <= '0;
            cnt_q      <= '0;
            csum_q     <= '0;
        end else begin
            wr_en_q <= 1'b0;
            case (state_q)
                LD_IDLE: begin
                    if (byte_accept) begin
                        if (header_ok(in_data)) begin
                            n_q     <= in_data[WORD_CNT_SIZE-1:0];
                            state_q <= LD_DATA;
                        end else begin
                            state_q    <= LD_ERROR;
                            err_q      <= 1'b1;
                            cpu_hold_q <= 1'b1;
                            in_ready_q <= 1'b0;
                        end
                    end
                end
                LD_DATA: begin
                    if (byte_accept) begin
                        csum_q <= csum_q ^ in_data;
                        if (pad_err) begin
                            state_q    <= LD_ERROR;
                            err_q      <= 1'b1;
                            cpu_hold_q <= 1'b1;
                            in_ready_q <= 1'b0;
                        end else if (word_valid) begin
                            wr_en_q   <= 1'b1;
                            wr_addr_q <= cnt_q[CMD_ADDR_SIZE-1:0];
                            wr_data_q <= word;
                            cnt_q     <= cnt_plus1;
                            if (cnt_plus1 == n_q) begin
                                state_q <= LD_CHECK;
                            end
                        end
                    end
                end
                LD_CHECK: begin
                    if (byte_accept) begin
                        in_ready_q <= 1'b0;
                        if (in_data == csum_q) begin
                            state_q    <= LD_DONE;
                            done_q     <= 1'b1;
                            cpu_hold_q <= 1'b0;
                        end else begin
                            state_q    <= LD_ERROR;
                            err_q      <= 1'b1;
                            cpu_hold_q <= 1'b1;
                        end
                    end
                end
                LD_DONE, LD_ERROR: begin
                    if (start) begin
                        state_q    <= LD_IDLE;
                        in_ready_q <= 1'b1;
                        cpu_hold_q <= 1'b1;
                        done_q     <= 1'b0;
                        err_q      <= 1'b0;
                        n_q        <= '0;
                        cnt_q      <= '0;
                        csum_q     <= '0;
                    end
                end
                default: begin
                    state_q    <= LD_IDLE;
                    in_ready_q <= 1'b1;
                    cpu_hold_q <= 1'b1;
                    done_q     <= 1'b0;
                    err_q      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready = in_ready_q;
    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign cpu_hold = cpu_hold_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule

// File: tb/tb_cmd_loader.sv
// Directed bench for cmd_loader: expected memory writes are queued as frames
// are driven and checked against the write port as wr_en pulses.
module tb_cmd_loader;
    import cpu_pkg::*;

    logic                     clk = 1'b0;
    logic                     reset;
    logic [BYTE_SIZE-1:0]     in_data;
    logic                     in_valid;
    logic                     in_ready;
    logic                     start;
    logic                     wr_en;
    logic [CMD_ADDR_SIZE-1:0] wr_addr;
    logic [CMD_SIZE-1:0]      wr_data;
    logic                     cpu_hold;
    logic                     done;
    logic                     err;

    int checksTotal  = 0;
    int checksPassed = 0;
    int wrCount      = 0;
    int wrBase       = 0;
    logic [23:0] expQ[$];
    logic [23:0] popped;

    localparam logic [CMD_SIZE-1:0] WORD0 = 19'h08001;
    localparam logic [CMD_SIZE-1:0] WORD1 = 19'h48009;

    always #5 clk = ~clk;

    cmd_loader dut (
        .clk      (clk),
        .reset    (reset),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .start    (start),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .cpu_hold (cpu_hold),
        .done     (done),
        .err      (err)
    );

    // One comparison: count it, and report tag/observed/expected on a miss
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checksTotal++;
        assert (observed === expected) checksPassed++;
        else begin
            $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
            $error("[TB] check %s miscompared", tag);
        end
    endtask

    // Scoreboard side: every write strobe must match the oldest queued write
    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            wrCount++;
            checkOutput("write_expected", 32'(expQ.size() != 0), 32'd1);
            if (expQ.size() != 0) begin
                popped = expQ.pop_front();
                checkOutput("write_addr", 32'(wr_addr), 32'(popped[23:19]));
                checkOutput("write_data", 32'(wr_data), 32'(popped[18:0]));
            end
        end
    end

    // Offer one byte after idle low cycles, wait (bounded) for it to transfer
    task automatic applyStimulus(input logic [7:0] b, input int idle);
        int waited;
        waited = 0;
        in_valid = 1'b0;
        repeat (idle) @(negedge clk);
        in_data  = b;
        in_valid = 1'b1;
        while (in_ready !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (in_ready !== 1'b1) begin
            checkOutput("ready_timeout", 32'(in_ready), 32'd1);
        end else begin
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    // Hold a byte on the bus for one cycle whether or not it is taken
    task automatic driveRaw(input logic [7:0] b);
        in_data  = b;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic sendWord(input logic [4:0] addr, input logic [18:0] w, input int idle);
        logic [7:0] b0;
        b0 = {5'b0, w[18:16]};
        expQ.push_back({addr, w});
        applyStimulus(b0, idle);
        applyStimulus(w[15:8], idle);
        applyStimulus(w[7:0], idle);
    endtask

    task automatic sendFrame(input logic [7:0] csumFlip, input int idle);
        logic [7:0] cs;
        cs = {5'b0, WORD0[18:16]} ^ WORD0[15:8] ^ WORD0[7:0]
           ^ {5'b0, WORD1[18:16]} ^ WORD1[15:8] ^ WORD1[7:0];
        applyStimulus(8'h02, idle);
        sendWord(5'd0, WORD0, idle);
        sendWord(5'd1, WORD1, idle);
        applyStimulus(cs ^ csumFlip, idle);
    endtask

    task automatic pulseStart();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("restart_done", 32'(done), 32'd0);
        checkOutput("restart_err", 32'(err), 32'd0);
        checkOutput("restart_hold", 32'(cpu_hold), 32'd1);
        checkOutput("restart_ready", 32'(in_ready), 32'd1);
    endtask

    task automatic doReset();
        reset    = 1'b0;
        in_valid = 1'b0;
        start    = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic checkDone(input string tag, input int writes);
        checkOutput({tag, "_done"}, 32'(done), 32'd1);
        checkOutput({tag, "_hold"}, 32'(cpu_hold), 32'd0);
        checkOutput({tag, "_err"}, 32'(err), 32'd0);
        checkOutput({tag, "_ready"}, 32'(in_ready), 32'd0);
        checkOutput({tag, "_wrcount"}, 32'(wrCount - wrBase), 32'(writes));
        checkOutput({tag, "_pending"}, 32'(expQ.size()), 32'd0);
    endtask

    task automatic checkError(input string tag, input int writes);
        checkOutput({tag, "_err"}, 32'(err), 32'd1);
        checkOutput({tag, "_done"}, 32'(done), 32'd0);
        checkOutput({tag, "_hold"}, 32'(cpu_hold), 32'd1);
        checkOutput({tag, "_ready"}, 32'(in_ready), 32'd0);
        checkOutput({tag, "_wrcount"}, 32'(wrCount - wrBase), 32'(writes));
    endtask

    // Hard stop in case something hangs outside the bounded waits
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed=running expected=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        start    = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;

        $display("[TB] reset state");
        checkOutput("rst_ready", 32'(in_ready), 32'd1);
        checkOutput("rst_wr_en", 32'(wr_en), 32'd0);
        checkOutput("rst_wr_addr", 32'(wr_addr), 32'd0);
        checkOutput("rst_wr_data", 32'(wr_data), 32'd0);
        checkOutput("rst_hold", 32'(cpu_hold), 32'd1);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_err", 32'(err), 32'd0);

        $display("[TB] good two-word frame");
        wrBase = wrCount;
        sendFrame(8'h00, 0);
        checkDone("good", 2);
        pulseStart();

        $display("[TB] oversize header");
        wrBase = wrCount;
        applyStimulus(8'h21, 0);
        checkError("hdr33", 0);
        pulseStart();

        $display("[TB] zero header");
        wrBase = wrCount;
        applyStimulus(8'h00, 0);
        checkError("hdr0", 0);
        pulseStart();

        $display("[TB] bad padding");
        wrBase = wrCount;
        applyStimulus(8'h01, 0);
        applyStimulus(8'h08, 0);
        driveRaw(8'h00);
        driveRaw(8'h00);
        repeat (2) @(negedge clk);
        checkError("pad", 0);
        pulseStart();

        $display("[TB] bad checksum then reload");
        wrBase = wrCount;
        sendFrame(8'h01, 0);
        checkError("csum", 2);
        checkOutput("csum_pending", 32'(expQ.size()), 32'd0);
        pulseStart();
        wrBase = wrCount;
        sendFrame(8'h00, 0);
        checkDone("reload", 2);
        pulseStart();

        $display("[TB] gapped valid");
        wrBase = wrCount;
        sendFrame(8'h00, 2);
        checkDone("gapped", 2);
        pulseStart();

        $display("[TB] reset mid-frame");
        wrBase = wrCount;
        applyStimulus(8'h02, 0);
        sendWord(5'd0, WORD0, 0);
        applyStimulus(8'h04, 0);
        doReset();
        checkOutput("midrst_wrcount", 32'(wrCount - wrBase), 32'd1);
        checkOutput("midrst_ready", 32'(in_ready), 32'd1);
        checkOutput("midrst_hold", 32'(cpu_hold), 32'd1);
        checkOutput("midrst_wr_en", 32'(wr_en), 32'd0);
        wrBase = wrCount;
        sendFrame(8'h00, 0);
        checkDone("afterrst", 2);

        $display("[TB] largest legal header");
        doReset();
        applyStimulus(8'h20, 0);
        checkOutput("hdr32_err", 32'(err), 32'd0);
        checkOutput("hdr32_ready", 32'(in_ready), 32'd1);
        doReset();

        repeat (2) @(negedge clk);
        $display("[TB] %0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end

endmodule
